// File: rtl/alu_issue_scheduler.sv
// ----------------------------------------------------------------------------
// alu_issue_scheduler
//   Reservation station in front of a single integer ALU. It holds up to DEPTH
//   dispatched instructions, wakes their operands from the common data bus,
//   and issues the lowest-index entry whose operands are both ready. Issue is
//   registered: the chosen entry appears on issue_* with alu_request_o high
//   for one cycle after the edge that selected it.
//
// Ports
//   clk_i, reset_i (async, active low)
//   dispatch_*_i / dispatch_ready_o : one-instruction-per-cycle dispatch handshake
//   cdb_valid_i, cdb_tag_i, cdb_value_i : result broadcast used for wakeup
//   flush_i                         : drop every held instruction
//   alu_request_o, issue_*_o        : registered issue towards the ALU
//   occupancy_o                     : count of valid entries (registered)
// ----------------------------------------------------------------------------
module alu_issue_scheduler #(
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int OCC_W = IDX_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             dispatch_valid_i,
    output logic             dispatch_ready_o,
    input  logic [31:0]      dispatch_pc_i,
    input  logic [31:0]      dispatch_inst_i,
    input  logic             dispatch_rs1_rdy_i,
    input  logic             dispatch_rs2_rdy_i,
    input  logic [TAG_W-1:0] dispatch_rs1_tag_i,
    input  logic [TAG_W-1:0] dispatch_rs2_tag_i,
    input  logic [31:0]      dispatch_rs1_val_i,
    input  logic [31:0]      dispatch_rs2_val_i,
    input  logic [TAG_W-1:0] dispatch_dest_tag_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [31:0]      cdb_value_i,
    input  logic             flush_i,
    output logic             alu_request_o,
    output logic [31:0]      issue_pc_o,
    output logic [31:0]      issue_inst_o,
    output logic [31:0]      issue_rs1_value_o,
    output logic [31:0]      issue_rs2_value_o,
    output logic [TAG_W-1:0] issue_dest_tag_o,
    output logic [OCC_W-1:0] occupancy_o
);

    // Control state (reset) and payload (no reset; only meaningful when valid).
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rdy1_q,  rdy1_d;
    logic [DEPTH-1:0] rdy2_q,  rdy2_d;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      inst_d [DEPTH];
    logic [31:0]      val1_q [DEPTH];
    logic [31:0]      val1_d [DEPTH];
    logic [31:0]      val2_q [DEPTH];
    logic [31:0]      val2_d [DEPTH];
    logic [TAG_W-1:0] tag1_q [DEPTH];
    logic [TAG_W-1:0] tag1_d [DEPTH];
    logic [TAG_W-1:0] tag2_q [DEPTH];
    logic [TAG_W-1:0] tag2_d [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];

    logic             req_q, req_d;
    logic [31:0]      iss_pc_q, iss_pc_d;
    logic [31:0]      iss_inst_q, iss_inst_d;
    logic [31:0]      iss_v1_q, iss_v1_d;
    logic [31:0]      iss_v2_q, iss_v2_d;
    logic [TAG_W-1:0] iss_dest_q, iss_dest_d;

    logic [DEPTH-1:0] eligible;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic [OCC_W-1:0] occ;
    logic             accept;

    // Eligibility and free-slot search look only at registered state, so an
    // operand woken this cycle (or a slot freed by this cycle's issue) is seen
    // one cycle later.
    always_comb begin
        eligible = valid_q & rdy1_q & rdy2_q;
        sel_idx  = '0;
        free_idx = '0;
        occ      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) sel_idx = IDX_W'(i);
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + {{(OCC_W-1){1'b0}}, valid_q[i]};
        end
    end

    assign dispatch_ready_o = ~&valid_q;
    assign accept           = dispatch_valid_i & dispatch_ready_o & ~flush_i;

    always_comb begin
        valid_d    = valid_q;
        rdy1_d     = rdy1_q;
        rdy2_d     = rdy2_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        val1_d     = val1_q;
        val2_d     = val2_q;
        tag1_d     = tag1_q;
        tag2_d     = tag2_q;
        dest_d     = dest_q;
        req_d      = 1'b0;
        iss_pc_d   = iss_pc_q;
        iss_inst_d = iss_inst_q;
        iss_v1_d   = iss_v1_q;
        iss_v2_d   = iss_v2_q;
        iss_dest_d = iss_dest_q;

        if (flush_i) begin
            valid_d = '0;
        end else begin
            if (cdb_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && !rdy1_q[i] && tag1_q[i] == cdb_tag_i) begin
                        rdy1_d[i] = 1'b1;
                        val1_d[i] = cdb_value_i;
                    end
                    if (valid_q[i] && !rdy2_q[i] && tag2_q[i] == cdb_tag_i) begin
                        rdy2_d[i] = 1'b1;
                        val2_d[i] = cdb_value_i;
                    end
                end
            end

            if (|eligible) begin
                req_d            = 1'b1;
                iss_pc_d         = pc_q[sel_idx];
                iss_inst_d       = inst_q[sel_idx];
                iss_v1_d         = val1_q[sel_idx];
                iss_v2_d         = val2_q[sel_idx];
                iss_dest_d       = dest_q[sel_idx];
                valid_d[sel_idx] = 1'b0;
            end

            // free_idx is an invalid slot, so it never collides with sel_idx
            // or with the wakeup updates above.
            if (accept) begin
                valid_d[free_idx] = 1'b1;
                pc_d[free_idx]    = dispatch_pc_i;
                inst_d[free_idx]  = dispatch_inst_i;
                dest_d[free_idx]  = dispatch_dest_tag_i;
                tag1_d[free_idx]  = dispatch_rs1_tag_i;
                tag2_d[free_idx]  = dispatch_rs2_tag_i;
                rdy1_d[free_idx]  = dispatch_rs1_rdy_i;
                val1_d[free_idx]  = dispatch_rs1_val_i;
                rdy2_d[free_idx]  = dispatch_rs2_rdy_i;
                val2_d[free_idx]  = dispatch_rs2_val_i;
                // Bypass a result broadcast in the very cycle of dispatch.
                if (!dispatch_rs1_rdy_i && cdb_valid_i && dispatch_rs1_tag_i == cdb_tag_i) begin
                    rdy1_d[free_idx] = 1'b1;
                    val1_d[free_idx] = cdb_value_i;
                end
                if (!dispatch_rs2_rdy_i && cdb_valid_i && dispatch_rs2_tag_i == cdb_tag_i) begin
                    rdy2_d[free_idx] = 1'b1;
                    val2_d[free_idx] = cdb_value_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q    <= '0;
            rdy1_q     <= '0;
            rdy2_q     <= '0;
            req_q      <= 1'b0;
            iss_pc_q   <= '0;
            iss_inst_q <= '0;
            iss_v1_q   <= '0;
            iss_v2_q   <= '0;
            iss_dest_q <= '0;
        end else begin
            valid_q    <= valid_d;
            rdy1_q     <= rdy1_d;
            rdy2_q     <= rdy2_d;
            req_q      <= req_d;
            iss_pc_q   <= iss_pc_d;
            iss_inst_q <= iss_inst_d;
            iss_v1_q   <= iss_v1_d;
            iss_v2_q   <= iss_v2_d;
            iss_dest_q <= iss_dest_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
        tag1_q <= tag1_d;
        tag2_q <= tag2_d;
        dest_q <= dest_d;
    end

    assign alu_request_o     = req_q;
    assign issue_pc_o        = iss_pc_q;
    assign issue_inst_o      = iss_inst_q;
    assign issue_rs1_value_o = iss_v1_q;
    assign issue_rs2_value_o = iss_v2_q;
    assign issue_dest_tag_o  = iss_dest_q;
    assign occupancy_o       = occ;

endmodule
